trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port trap_req, input, 1, trap entry request from the exception handler.
REQ-004 SHALL have port mret_req, input, 1, trap exit request.
REQ-005 SHALL have ports cause_in, epc_in, tval_in, mstatus_in and target_pc_in, each input, 64, trap record sampled at acceptance.
REQ-006 SHALL have port mem_busy, input, 1, memory transaction outstanding.
REQ-007 SHALL have port pipe_stall, output, 1, holds the pipeline.
REQ-008 SHALL have port pipe_flush, output, 1, one-cycle flush pulse.
REQ-009 SHALL have ports csr_wr_en (output, 1), csr_wr_addr (output, 12) and csr_wr_data (output, 64), forming the single CSR write port.
REQ-010 SHALL have ports redir_valid (output, 1), redir_pc (output, 64) and redir_ready (input, 1), forming the fetch redirect handshake.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, DRAIN, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS and REDIR.
REQ-013 In IDLE with trap_req=1, SHALL latch the five 64-bit inputs, set kind=TRAP, pulse pipe_flush for that cycle and go to DRAIN.
REQ-014 In IDLE with mret_req=1 and trap_req=0, SHALL latch mstatus_in and target_pc_in, set kind=MRET, pulse pipe_flush and go to DRAIN.
REQ-015 SHALL give trap_req priority when trap_req and mret_req are high together, and SHALL drop the mret.
REQ-016 SHALL ignore trap_req and mret_req in every state except IDLE, with no queuing.
REQ-017 SHALL stay in DRAIN for at least one cycle and SHALL leave it on the first cycle with mem_busy=0.
REQ-018 On leaving DRAIN, SHALL go to W_MEPC when kind=TRAP and to W_MSTATUS when kind=MRET.
REQ-019 SHALL assert csr_wr_en for exactly one cycle in each W_ state, with addresses W_MEPC=0x341, W_MCAUSE=0x342, W_MTVAL=0x343 and W_MSTATUS=0x300, and data equal to the matching latched value.
REQ-020 SHALL follow the TRAP sequence W_MEPC -> W_MCAUSE -> W_MTVAL -> W_MSTATUS -> REDIR.
REQ-021 SHALL hold csr_wr_en=0, csr_wr_addr=0 and csr_wr_data=0 outside the W_ states.
REQ-022 In REDIR, SHALL hold redir_valid=1 with redir_pc equal to the latched target.
REQ-023 SHALL complete the redirect on the first cycle with redir_ready=1 and go to IDLE on the next edge; redir_pc SHALL stay stable while redir_valid=1 and redir_ready=0.
REQ-024 SHALL hold redir_pc=0 whenever redir_valid=0.
REQ-025 SHALL drive pipe_stall=1 in every state except IDLE, and also in the IDLE acceptance cycle.
REQ-026 SHALL give a TRAP with mem_busy=0 and redir_ready=1 a latency of 7 cycles from acceptance to return to IDLE, and an MRET a latency of 4 cycles.
REQ-027 SHALL ignore mem_busy outside DRAIN.

Reset
REQ-028 With reset=1 on an edge, SHALL set state=IDLE and clear all latches and kind, from any state, including mid-DRAIN or mid-REDIR.
REQ-029 While reset=1 and on the cycle after it, SHALL hold all outputs at 0.
REQ-030 SHALL accept no request in a cycle where reset=1.

Configuration
REQ-031 With macro TRAP_MTVAL_WRITE_EN defined, SHALL include W_MTVAL in the TRAP sequence.
REQ-032 With TRAP_MTVAL_WRITE_EN undefined, SHALL omit W_MTVAL, go from W_MCAUSE directly to W_MSTATUS, never emit address 0x343, and leave tval_in unused; TRAP latency SHALL then be 6 cycles.

Verification
REQ-033 Cover this scenario with the macro defined: trap_req at cycle 0 with epc=0x8000_0010, cause=0x2, tval=0x13, mstatus=0x80, target=0x8000_1000, mem_busy=0 and redir_ready=1 -> pipe_flush at cycle 0, then CSR writes 0x341/0x8000_0010 at cycle 2, 0x342/0x2 at cycle 3, 0x343/0x13 at cycle 4 and 0x300/0x80 at cycle 5, then redir_valid with redir_pc=0x8000_1000 at cycle 6, and busy=0 at cycle 7.
REQ-034 Cover this scenario: a trap with mem_busy=1 for cycles 0-4 -> state stays DRAIN through cycle 4 and the first CSR write (0x341) occurs at cycle 6.
REQ-035 Cover this scenario: mret_req with mstatus=0x88 and target=0x8000_0014 -> a single CSR write 0x300/0x88 at cycle 2, then redir_pc=0x8000_0014 at cycle 3.
REQ-036 Cover this scenario: trap_req and mret_req both high in IDLE -> the TRAP sequence runs, and no further request is accepted until busy falls.
REQ-037 Cover this scenario: redir_ready=0 for 5 cycles in REDIR -> redir_valid and redir_pc stay stable and no CSR write occurs; then reset=1 in REDIR -> all outputs are 0 on the next cycle.
REQ-038 Cover this scenario with the macro undefined: a trap -> writes only to 0x341, 0x342 and 0x300, and busy falls at cycle 6.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap entry/exit sequencer: flushes the pipe, waits for memory to drain, writes the
// trap CSRs one per cycle, then redirects fetch. Define TRAP_MTVAL_WRITE_EN to include the mtval write.
module trap_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        trap_req,
  input  logic        mret_req,
  input  logic [63:0] cause_in,
  input  logic [63:0] epc_in,
  input  logic [63:0] tval_in,
  input  logic [63:0] mstatus_in,
  input  logic [63:0] target_pc_in,
  input  logic        mem_busy,
  output logic        pipe_stall,
  output logic        pipe_flush,
  output logic        csr_wr_en,
  output logic [11:0] csr_wr_addr,
  output logic [63:0] csr_wr_data,
  output logic        redir_valid,
  output logic [63:0] redir_pc,
  input  logic        redir_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, DRAIN, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, REDIR
  } state_e;

  typedef enum logic {K_TRAP, K_MRET} kind_e;

  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [11:0] A_MSTATUS = 12'h300;

  state_e      state_q;
  kind_e       kind_q;
  logic        rst_q;
  logic [63:0] cause_q, epc_q, mstatus_q, target_q;
  logic        accept;

`ifdef TRAP_MTVAL_WRITE_EN
  logic [63:0] tval_q;
`else
  logic        unused_tval;
  assign unused_tval = ^tval_in;
`endif

  // rst_q blocks acceptance on the cycle after reset so every output stays quiet there.
  assign accept = !reset && !rst_q && (state_q == IDLE) && (trap_req || mret_req);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      kind_q    <= K_TRAP;
      rst_q     <= 1'b1;
      cause_q   <= '0;
      epc_q     <= '0;
      mstatus_q <= '0;
      target_q  <= '0;
`ifdef TRAP_MTVAL_WRITE_EN
      tval_q    <= '0;
`endif
    end else begin
      rst_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          kind_q    <= trap_req ? K_TRAP : K_MRET;
          mstatus_q <= mstatus_in;
          target_q  <= target_pc_in;
          if (trap_req) begin
            cause_q <= cause_in;
            epc_q   <= epc_in;
`ifdef TRAP_MTVAL_WRITE_EN
            tval_q  <= tval_in;
`endif
          end
          state_q <= DRAIN;
        end
        DRAIN:     if (!mem_busy) state_q <= (kind_q == K_TRAP) ? W_MEPC : W_MSTATUS;
        W_MEPC:    state_q <= W_MCAUSE;
`ifdef TRAP_MTVAL_WRITE_EN
        W_MCAUSE:  state_q <= W_MTVAL;
`else
        W_MCAUSE:  state_q <= W_MSTATUS;
`endif
        W_MTVAL:   state_q <= W_MSTATUS;
        W_MSTATUS: state_q <= REDIR;
        REDIR:     if (redir_ready) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    pipe_stall  = 1'b0;
    pipe_flush  = 1'b0;
    csr_wr_en   = 1'b0;
    csr_wr_addr = '0;
    csr_wr_data = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    busy        = 1'b0;
    if (!reset) begin
      busy       = (state_q != IDLE);
      pipe_flush = accept;
      pipe_stall = busy || accept;
      case (state_q)
        W_MEPC:    begin csr_wr_en = 1'b1; csr_wr_addr = A_MEPC;    csr_wr_data = epc_q;     end
        W_MCAUSE:  begin csr_wr_en = 1'b1; csr_wr_addr = A_MCAUSE;  csr_wr_data = cause_q;   end
`ifdef TRAP_MTVAL_WRITE_EN
        W_MTVAL:   begin csr_wr_en = 1'b1; csr_wr_addr = A_MTVAL;   csr_wr_data = tval_q;    end
`endif
        W_MSTATUS: begin csr_wr_en = 1'b1; csr_wr_addr = A_MSTATUS; csr_wr_data = mstatus_q; end
        REDIR:     begin redir_valid = 1'b1; redir_pc = target_q; end
        default:   ;
      endcase
    end
  end

endmodule
